// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the receiver and transmitter.
//   rx_state_t       receiver FSM state encoding
//   PS2_DATA_BITS    data bits per PS/2 frame
//   PS2_TIMEOUT_2MS  2 ms in 50 MHz clk cycles, used as the mid-frame watchdog
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_TIMEOUT_2MS = 100000;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. Deserialises 11-bit frames (start 0, 8 data bits
// LSB first, odd parity, stop 1) and detects the device line-ack that closes a
// host-to-device transfer.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RX_IDLE   | waiting for a start bit (or a line-ack while tx_ack_wait)
// RX_DATA   | shifting in the 8 data bits
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking the stop bit, then reporting the frame result
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk_negedge   1-cycle pulse on each synchronised PS/2 clock fall
//   ps2_data_i        synchronised PS/2 data line
//   rx_inhibit        transmitter owns the bus; no frame start, rising edge aborts a frame
//   tx_ack_wait       transmitter awaits the device line-ack
//   rx_data           last good byte, held until the next good frame
//   rx_valid / rx_parity_err / rx_frame_err / rx_timeout / rx_ack   1-cycle event pulses
//   rx_busy           receiver is inside a frame
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_2MS,
    parameter int TMO_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data_i,
    input  logic       rx_inhibit,
    input  logic       tx_ack_wait,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_ack,
    output logic       rx_busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_DATA_BITS - 1);

    rx_state_t        state, state_next;
    logic [3:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift, shift_next;
    logic             par_bit, par_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic             inhibit_q;
    logic [7:0]       data_next;
    logic             valid_next, par_err_next, frame_err_next, tmo_pulse_next, ack_next;
    logic             abort, tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RX_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            tmo_cnt       <= '0;
            inhibit_q     <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_timeout    <= 1'b0;
            rx_ack        <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            state         <= state_next;
            bit_cnt       <= bit_cnt_next;
            shift         <= shift_next;
            par_bit       <= par_next;
            tmo_cnt       <= tmo_next;
            inhibit_q     <= rx_inhibit;
            rx_data       <= data_next;
            rx_valid      <= valid_next;
            rx_parity_err <= par_err_next;
            rx_frame_err  <= frame_err_next;
            rx_timeout    <= tmo_pulse_next;
            rx_ack        <= ack_next;
            rx_busy       <= (state_next != RX_IDLE);
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift;
        par_next       = par_bit;
        data_next      = rx_data;
        valid_next     = 1'b0;
        par_err_next   = 1'b0;
        frame_err_next = 1'b0;
        tmo_pulse_next = 1'b0;
        ack_next       = 1'b0;
        tmo_next       = '0;

        if (state != RX_IDLE) begin
            tmo_next = ps2_clk_negedge ? '0 : tmo_cnt + TMO_ONE;
        end

        // Transmitter grabbing the bus kills a frame silently; a negedge in the
        // same cycle as the last watchdog count keeps the frame alive.
        abort   = rx_inhibit && !inhibit_q && (state != RX_IDLE);
        tmo_hit = (state != RX_IDLE) && !ps2_clk_negedge && (tmo_cnt == TMO_LAST);

        if (abort) begin
            state_next = RX_IDLE;
        end else if (tmo_hit) begin
            state_next     = RX_IDLE;
            tmo_pulse_next = 1'b1;
        end else if (ps2_clk_negedge) begin
            case (state)
                RX_IDLE: begin
                    if (!ps2_data_i) begin
                        if (tx_ack_wait) begin
                            ack_next = 1'b1;
                        end else if (!rx_inhibit) begin
                            state_next   = RX_DATA;
                            bit_cnt_next = '0;
                        end
                    end
                end
                RX_DATA: begin
                    shift_next   = {ps2_data_i, shift[7:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_next   = ps2_data_i;
                    state_next = RX_STOP;
                end
                RX_STOP: begin
                    state_next = RX_IDLE;
                    if (!ps2_data_i) begin
                        frame_err_next = 1'b1;
                    end else if (^{shift, par_bit} == 1'b0) begin
                        par_err_next = 1'b1;
                    end else begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end

        if (state_next == RX_IDLE) begin
            tmo_next = '0;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ne  = 1'b0;
    logic       pd  = 1'b1;
    logic       inh = 1'b0;
    logic       ackw = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_ack, rx_busy;

    ps2_rx #(.TIMEOUT_CYCLES(TMO), .TMO_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk_negedge (ne),
        .ps2_data_i      (pd),
        .rx_inhibit      (inh),
        .tx_ack_wait     (ackw),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_parity_err   (rx_parity_err),
        .rx_frame_err    (rx_frame_err),
        .rx_timeout      (rx_timeout),
        .rx_ack          (rx_ack),
        .rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_VALID, EV_PAR, EV_FRAME, EV_TMO, EV_ACK} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        ev_kind_t   kind;
    } vec_t;

    exp_t       sb[$];
    logic [7:0] model_data = 8'h00;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic void check(string name, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Event monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        logic [4:0] pulses;
        int         k;
        exp_t       e;
        if (!rst) begin
            pulses = {rx_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_ack};
            if (pulses != 5'b0) begin
                check("one_pulse", $countones(pulses), 1);
                k = rx_valid ? EV_VALID : rx_parity_err ? EV_PAR :
                    rx_frame_err ? EV_FRAME : rx_timeout ? EV_TMO : EV_ACK;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", k, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ev_kind", k, e.kind);
                    check("ev_data", rx_data, e.data);
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_busy", rx_busy, 0);
                end
            end
        end
    end

    task automatic drive_edge(input logic b, output int at);
        @(negedge clk);
        pd = b;
        ne = 1'b1;
        at = cyc;
    endtask

    task automatic end_edge();
        @(negedge clk);
        ne = 1'b0;
        pd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        int at;
        drive_edge(b, at);
        end_edge();
    endtask

    task automatic send_head(input logic [7:0] d, input int nbits);
        ps2_bit(1'b0);
        check("busy_mid", rx_busy, 1);
        for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input ev_kind_t kind);
        int at;
        send_head(d, 8);
        ps2_bit(par);
        drive_edge(stop, at);
        if (kind == EV_VALID) model_data = d;
        sb.push_back('{kind: kind, data: model_data, cyc: at + 1});
        end_edge();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, rx_data, model_data);
        check({tag, "_busy"}, rx_busy, 0);
        check({tag, "_pulses"},
              {27'b0, rx_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_ack}, 0);
    endtask

    vec_t vecs[10];

    initial begin
        int at;
        vecs = '{
            '{8'hA5, 1'b1, 1'b1, EV_VALID},
            '{8'hFA, 1'b0, 1'b1, EV_PAR},
            '{8'h01, 1'b0, 1'b0, EV_FRAME},
            '{8'hFF, 1'b1, 1'b1, EV_VALID},
            '{8'h80, 1'b0, 1'b1, EV_VALID},
            '{8'h7E, 1'b0, 1'b1, EV_PAR},
            '{8'h55, 1'b1, 1'b0, EV_FRAME},
            '{8'h00, 1'b0, 1'b0, EV_FRAME},
            '{8'h3C, 1'b0, 1'b1, EV_PAR},
            '{8'h96, 1'b1, 1'b1, EV_VALID}
        };

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].kind);
        end

        // Line-ack has priority over a frame start; inhibit blocks a start.
        ackw = 1'b1;
        drive_edge(1'b0, at);
        sb.push_back('{kind: EV_ACK, data: model_data, cyc: at + 1});
        end_edge();
        check("ack_busy", rx_busy, 0);
        ackw = 1'b0;
        inh  = 1'b1;
        @(negedge clk);
        ps2_bit(1'b0);
        check("inhibit_busy", rx_busy, 0);
        ps2_bit(1'b1);
        inh = 1'b0;
        @(negedge clk);

        // Inhibit rising mid-frame aborts silently; no later watchdog event.
        send_head(8'hC3, 3);
        inh = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_busy", rx_busy, 0);
        inh = 1'b0;
        repeat (TMO + 10) @(negedge clk);
        check("abort_data", rx_data, model_data);
        send_frame(8'h81, 1'b1, 1'b1, EV_VALID);

        // Reset mid-frame.
        send_head(8'h3C, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_data = 8'h00;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, EV_VALID);

        // Watchdog: pulse exactly TMO cycles after the last negedge edge.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        drive_edge(1'b1, at);
        sb.push_back('{kind: EV_TMO, data: model_data, cyc: at + 1 + TMO});
        end_edge();
        repeat (TMO + 10) @(negedge clk);
        check("tmo_busy", rx_busy, 0);
        send_frame(8'h00, 1'b1, 1'b1, EV_VALID);

        repeat (10) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_data", rx_data, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
